pr_pipe_slice: RTL
==================

PR_PIPE_SLICE -- requirements
Module: pr_pipe_slice

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 128: payload width in bits (1..1024).
REQ-002 The block SHALL have parameter REG_TYPE, default 2: 0 = bypass wires; 1 = forward register with combinational ready; 2 = skid buffer with all outputs registered.
REQ-003 The block SHALL have parameter REG_LENGTH, default 1: number of cascaded stages (1..8).
REQ-004 The block SHALL have derived constant OCC_W = $clog2(2*REG_LENGTH+1): occupancy counter width.
REQ-005 The block SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-007 The block SHALL have port flush, input, 1: synchronous discard of all held entries.
REQ-008 The block SHALL have port s_data, input, DATA_WIDTH: upstream payload.
REQ-009 The block SHALL have port s_valid, input, 1: upstream valid.
REQ-010 The block SHALL have port s_ready, output, 1: block can accept a beat.
REQ-011 The block SHALL have port m_data, output, DATA_WIDTH: downstream payload.
REQ-012 The block SHALL have port m_valid, output, 1: downstream valid.
REQ-013 The block SHALL have port m_ready, input, 1: downstream accepts a beat.
REQ-014 The block SHALL have port occupancy, output, OCC_W: number of beats currently held, registered.

Function
REQ-015 A beat SHALL transfer on any cycle where valid and ready are both high; a beat SHALL never be duplicated, dropped (except by flush), or reordered.
REQ-016 REG_TYPE=0: m_data = s_data, m_valid = s_valid and s_ready = m_ready, all combinationally; occupancy SHALL be 0; flush SHALL have no effect.
REQ-017 REG_TYPE=1: each stage SHALL hold 1 entry and be ready when empty or when its downstream ready is high (a combinational ready chain); latency SHALL be REG_LENGTH cycles.
REQ-018 REG_TYPE=2: each stage SHALL hold a main register and a skid register.
REQ-019 For REG_TYPE=2, s_ready SHALL be a flop equal to "skid empty".
REQ-020 For REG_TYPE=2, a beat arriving while the main register is full and downstream is stalled SHALL go to the skid register.
REQ-021 For REG_TYPE=2, the skid register SHALL drain into main when downstream accepts.
REQ-022 For REG_TYPE=2, latency SHALL be REG_LENGTH cycles, with no combinational path from m_ready to s_ready.
REQ-023 Sustained throughput SHALL be 1 beat/cycle for all REG_TYPE values while m_ready=1.
REQ-024 Occupancy SHALL equal accepted-in minus accepted-out since the last reset or flush, bounded by REG_LENGTH (type 1) or 2*REG_LENGTH (type 2).
REQ-025 A simultaneous input and output transfer SHALL leave occupancy unchanged.
REQ-026 While flush=1: s_ready SHALL be 0 and m_valid SHALL be 0.
REQ-027 On the clock edge with flush=1, all valid/skid flags SHALL clear and occupancy SHALL be 0 in the next cycle.
REQ-028 Normal operation SHALL resume in the cycle after flush deasserts.
REQ-029 When full (type 2: every skid occupied), s_ready SHALL be 0; asserting s_valid then SHALL have no effect.
REQ-030 m_data SHALL hold stable while m_valid=1 and m_ready=0.
REQ-031 Data registers SHALL be non-reset, so that they are area-friendly for wide payloads; only control flops SHALL be reset.

Reset
REQ-032 Asserting rst SHALL immediately clear all valid and skid flags, drive m_valid=0 and occupancy=0, and set type-2 s_ready to 1 in the first cycle after rst deasserts (0 while rst is high).
REQ-033 Reset mid-transfer SHALL discard all held beats without emitting any of them.

Structure
REQ-034 Package pr_pipe_pkg SHALL hold the REG_TYPE encodings (REG_BYPASS=0, REG_FWD=1, REG_SKID=2) and an OCC_W helper function.
REQ-035 One sub-module, pr_pipe_stage (one stage, parametrised by DATA_WIDTH and REG_TYPE), SHALL be instantiated REG_LENGTH times in a generate loop.
REQ-036 The top level SHALL sum the per-stage counts into the registered occupancy output.

Verification
REQ-037 The bench SHALL cover: REG_TYPE=2, REG_LENGTH=1, m_ready=1, 8 beats 0x1..0x8 back-to-back -> outputs 0x1..0x8 with 1-cycle latency, s_ready never low.
REQ-038 The bench SHALL cover: REG_TYPE=2, REG_LENGTH=3, m_ready=0, 8 beats offered -> 6 accepted, s_ready low after the 6th, occupancy=6; then m_ready=1 -> 6 beats out in order.
REQ-039 The bench SHALL cover: REG_TYPE=1, REG_LENGTH=2, random s_valid/m_ready over 1000 beats -> scoreboard exact match, occupancy never above 2.
REQ-040 The bench SHALL cover: REG_TYPE=2, REG_LENGTH=2, 4 beats held, flush pulsed 1 cycle -> m_valid=0 during flush, occupancy=0 next cycle, next beat 0xAA emerges 2 cycles after acceptance.
REQ-041 The bench SHALL cover: rst asserted asynchronously mid-stream with 3 beats held -> m_valid=0 and occupancy=0 before the next clock edge; no stale beats appear after release.
REQ-042 The bench SHALL cover: REG_TYPE=0 -> m_data equals s_data in the same cycle, s_ready tracks m_ready, occupancy stays 0.

Source files
------------

// File: rtl/pr_pipe_pkg.sv
// Shared definitions for the pr_pipe register slice.
//   REG_BYPASS / REG_FWD / REG_SKID : encodings of the REG_TYPE parameter
//   occ_width()                      : width of an occupancy counter for a given stage count
package pr_pipe_pkg;

    localparam int unsigned REG_BYPASS = 0;
    localparam int unsigned REG_FWD    = 1;
    localparam int unsigned REG_SKID   = 2;

    // Each stage holds at most two beats, so the count spans 0..2*reg_length.
    function automatic int unsigned occ_width(input int unsigned reg_length);
        return $clog2(2 * reg_length + 1);
    endfunction

endpackage

// File: rtl/pr_pipe_stage.sv
// One valid/ready register stage.
//   clk, rst       : clock, asynchronous active-high reset
//   flush          : synchronous discard of held beats
//   s_data/s_valid/s_ready : upstream handshake
//   m_data/m_valid/m_ready : downstream handshake
//   count_next     : number of beats this stage will hold after the coming edge
module pr_pipe_stage
    import pr_pipe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned REG_TYPE   = REG_SKID
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [1:0]            count_next
);

    if (REG_TYPE == REG_BYPASS) begin : g_bypass
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, rst, flush};
        assign m_data      = s_data;
        assign m_valid     = s_valid;
        assign s_ready     = m_ready;
        assign count_next  = 2'd0;

    end else if (REG_TYPE == REG_FWD) begin : g_fwd
        logic                  valid_q, valid_d;
        logic [DATA_WIDTH-1:0] data_q;
        logic                  load;

        always_comb begin
            // Ready passes straight through from downstream when full.
            s_ready = !flush && (!valid_q || m_ready);
            m_valid = valid_q && !flush;
            m_data  = data_q;
            load    = s_valid && s_ready;
            valid_d = valid_q;
            if (flush) begin
                valid_d = 1'b0;
            end else if (s_ready) begin
                valid_d = s_valid;
            end
            count_next = {1'b0, valid_d};
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= 1'b0;
            end else begin
                valid_q <= valid_d;
            end
        end

        // Payload flops carry no reset.
        always_ff @(posedge clk) begin
            if (load) begin
                data_q <= s_data;
            end
        end

    end else begin : g_skid
        logic                  main_valid_q, main_valid_d;
        logic                  skid_valid_q, skid_valid_d;
        logic                  ready_q;
        logic [DATA_WIDTH-1:0] main_q, skid_q;
        logic                  in_fire, out_fire;
        logic                  load_main, load_skid, main_from_skid;

        always_comb begin
            // ready_q is a flop, so m_ready never reaches s_ready combinationally.
            s_ready        = ready_q && !flush;
            m_valid        = main_valid_q && !flush;
            m_data         = main_q;
            in_fire        = s_valid && s_ready;
            out_fire       = m_valid && m_ready;
            main_valid_d   = main_valid_q;
            skid_valid_d   = skid_valid_q;
            load_main      = 1'b0;
            load_skid      = 1'b0;
            main_from_skid = 1'b0;
            if (flush) begin
                main_valid_d = 1'b0;
                skid_valid_d = 1'b0;
            end else if (!main_valid_q || out_fire) begin
                // Main frees up: refill from skid first (s_ready is low then).
                if (skid_valid_q) begin
                    main_valid_d   = 1'b1;
                    skid_valid_d   = 1'b0;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end else begin
                    main_valid_d = in_fire;
                    load_main    = in_fire;
                end
            end else if (in_fire) begin
                // Main full and stalled: the beat parks in skid.
                skid_valid_d = 1'b1;
                load_skid    = 1'b1;
            end
            count_next = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                main_valid_q <= 1'b0;
                skid_valid_q <= 1'b0;
                ready_q      <= 1'b0;
            end else begin
                main_valid_q <= main_valid_d;
                skid_valid_q <= skid_valid_d;
                ready_q      <= !skid_valid_d;
            end
        end

        always_ff @(posedge clk) begin
            if (load_main) begin
                main_q <= main_from_skid ? skid_q : s_data;
            end
            if (load_skid) begin
                skid_q <= s_data;
            end
        end
    end

endmodule

// File: rtl/pr_pipe_slice.sv
// Cascade of REG_LENGTH pipeline register stages with a registered occupancy count.
//   clk, rst               : clock, asynchronous active-high reset
//   flush                  : synchronous discard of all held beats
//   s_data/s_valid/s_ready : upstream handshake
//   m_data/m_valid/m_ready : downstream handshake
//   occupancy              : beats currently held (0 in bypass mode)
module pr_pipe_slice
    import pr_pipe_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 128,
    parameter  int unsigned REG_TYPE   = REG_SKID,
    parameter  int unsigned REG_LENGTH = 1,
    localparam int unsigned OCC_W      = occ_width(REG_LENGTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [OCC_W-1:0]      occupancy
);

    logic [OCC_W-1:0] occ_d;

    // Per-stage signals live in each generate block so the ready chain is not one
    // self-referencing vector.
    for (genvar i = 0; i < int'(REG_LENGTH); i++) begin : g_stage
        logic [DATA_WIDTH-1:0] in_data, out_data;
        logic                  in_valid, in_ready, out_valid, out_ready;
        logic [1:0]            cnt_next;
        logic [OCC_W-1:0]      acc;

        pr_pipe_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .REG_TYPE   (REG_TYPE)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush),
            .s_data     (in_data),
            .s_valid    (in_valid),
            .s_ready    (in_ready),
            .m_data     (out_data),
            .m_valid    (out_valid),
            .m_ready    (out_ready),
            .count_next (cnt_next)
        );

        if (i == 0) begin : g_head
            assign in_data  = s_data;
            assign in_valid = s_valid;
            assign s_ready  = in_ready;
            assign acc      = OCC_W'(cnt_next);
        end else begin : g_link
            assign in_data  = g_stage[i-1].out_data;
            assign in_valid = g_stage[i-1].out_valid;
            assign acc      = g_stage[i-1].acc + OCC_W'(cnt_next);
        end

        if (i == int'(REG_LENGTH) - 1) begin : g_tail
            assign m_data    = out_data;
            assign m_valid   = out_valid;
            assign out_ready = m_ready;
        end else begin : g_mid
            assign out_ready = g_stage[i+1].in_ready;
        end
    end

    assign occ_d = g_stage[REG_LENGTH-1].acc;

    // Registering next-state counts keeps occupancy equal to the beats held now.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupancy <= '0;
        end else begin
            occupancy <= occ_d;
        end
    end

endmodule
